// File: rtl/mext_mul_ctrl.sv
// Execute-stage sequencer for RV32M MUL/MULH/MULHSU/MULHU around an iterative multiplier.
// Stalls E, pulses start, waits for ready (with watchdog) and issues a one-cycle writeback.
module mext_mul_ctrl #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_validE,
  input  logic [2:0]  funct3E,
  input  logic [31:0] rs1E,
  input  logic [31:0] rs2E,
  input  logic [4:0]  rdE,
  input  logic        flushE,
  output logic        stall_mul,
  output logic        mul_start,
  output logic [1:0]  mul_opcode,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  input  logic        mul_ready,
  input  logic [63:0] mul_product,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mul_err,
  output logic        busy
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]  r_rd;
  logic [1:0]  r_op;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic        r_start;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_err;

  logic        w_accept;
  logic        w_timeout;
  logic [31:0] w_result;

  // funct3E[2] set means div/rem, which belongs to a different unit.
  assign w_accept  = (r_state == S_IDLE) & mul_validE & ~funct3E[2] & ~flushE;
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_result  = (r_op == 2'b00) ? mul_product[31:0] : mul_product[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_op       <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_start    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_start    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op1   <= rs1E;
            r_op2   <= rs2E;
            r_op    <= funct3E[1:0];
            r_rd    <= rdE;
            r_start <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= flushE ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (flushE) begin
            r_state <= S_IDLE;
          end else if (mul_ready) begin
            // ready beats a coincident timeout
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_result;
            r_state    <= S_DONE;
          end else if (w_timeout) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_err      <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_mul  = w_accept | (r_state == S_LAUNCH) | (r_state == S_WAIT);
  assign busy       = (r_state != S_IDLE);
  assign mul_start  = r_start;
  assign mul_opcode = r_op;
  assign mul_op1    = r_op1;
  assign mul_op2    = r_op2;
  assign wb_valid   = r_wb_valid;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign mul_err    = r_err;

endmodule

// File: tb/tb_mext_mul_ctrl.sv
// Directed bench for mext_mul_ctrl with a behavioural multiplier of programmable latency.
module tb_mext_mul_ctrl;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mul_validE = 1'b0;
  logic [2:0]  funct3E = '0;
  logic [31:0] rs1E = '0, rs2E = '0;
  logic [4:0]  rdE = '0;
  logic        flushE = 1'b0;
  logic        stall_mul, mul_start, mul_ready;
  logic [1:0]  mul_opcode;
  logic [31:0] mul_op1, mul_op2;
  logic [63:0] mul_product;
  logic        wb_valid, mul_err, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0, failures = 0;
  int n_start = 0, n_stall = 0, n_wb = 0, n_err = 0;
  int m_lat = 34;
  logic m_dead = 1'b0;
  int m_cnt = 0;
  logic m_rdy = 1'b0;
  logic [63:0] m_prod = '0;

  mext_mul_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mul_validE(mul_validE), .funct3E(funct3E),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .flushE(flushE),
    .stall_mul(stall_mul), .mul_start(mul_start), .mul_opcode(mul_opcode),
    .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_ready(mul_ready),
    .mul_product(mul_product), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .mul_err(mul_err), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mul_ready   = m_rdy;
  assign mul_product = m_prod;

  function automatic logic [63:0] prod(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = (op == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (op[1]) ? {32'b0, b} : {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  // Behavioural multiplier: ready pulses L cycles after the start cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
      m_rdy <= 1'b0;
    end else begin
      m_rdy <= 1'b0;
      if (mul_start) begin
        m_prod <= prod(mul_opcode, mul_op1, mul_op2);
        m_cnt  <= m_dead ? 0 : m_lat - 1;
        if (!m_dead && m_lat == 1) m_rdy <= 1'b1;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_rdy <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (mul_start) n_start++;
    if (stall_mul) n_stall++;
    if (wb_valid)  n_wb++;
    if (mul_err)   n_err++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int lat,
                        input logic [31:0] exp, input logic exp_err, input int exp_cyc);
    int cyc, s_start, s_stall, s_wb, s_err;
    m_lat = lat;
    s_start = n_start; s_stall = n_stall; s_wb = n_wb; s_err = n_err;
    mul_validE = 1'b1; funct3E = f3; rs1E = a; rs2E = b; rdE = rd;
    #1;
    chk({tag, "_stall_T0"}, stall_mul, 1'b1);
    cyc = 0;
    do begin
      step();
      cyc++;
      if (cyc == 1) begin
        chk({tag, "_start_T1"}, mul_start, 1'b1);
        chk({tag, "_opcode"}, mul_opcode, f3[1:0]);
        chk({tag, "_ops"}, {mul_op1, mul_op2}, {a, b});
      end
    end while (!wb_valid && cyc < 200);
    mul_validE = 1'b0;
    #1;
    chk({tag, "_latency"}, cyc, exp_cyc);
    chk({tag, "_rd"}, wb_rd, rd);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_err"}, mul_err, exp_err);
    chk({tag, "_stall_done"}, stall_mul, 1'b0);
    step();
    chk({tag, "_nstart"}, n_start - s_start, 1);
    chk({tag, "_nstall"}, n_stall - s_stall, exp_cyc);
    chk({tag, "_nwb"}, n_wb - s_wb, 1);
    chk({tag, "_nerr"}, n_err - s_err, exp_err ? 1 : 0);
    chk({tag, "_idle"}, {busy, wb_valid, mul_err}, 3'b000);
  endtask

  initial begin
    int s_start, s_wb;
    step(); step();
    chk("rst_outs", {stall_mul, mul_start, wb_valid, mul_err, busy, wb_rd, wb_data,
                     mul_opcode, mul_op1, mul_op2}, '0);
    rst = 1'b0;
    step();

    run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 5'd5, 34, 32'h0000002A, 1'b0, 36);
    run_op("mulh",   3'b001, 32'hFFFFFFFE, 32'h3, 5'd6, 5, 32'hFFFFFFFF, 1'b0, 7);
    run_op("mulhu",  3'b011, 32'hFFFFFFFE, 32'h3, 5'd7, 5, 32'h00000002, 1'b0, 7);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 2, 32'hFFFFFFFF, 1'b0, 4);
    run_op("mul_ovf", 3'b000, 32'h80000000, 32'h2, 5'd9, 1, 32'h00000000, 1'b0, 3);

    // div/rem and flushed instructions are not accepted in IDLE
    mul_validE = 1'b1; funct3E = 3'b100; #1;
    chk("div_nostall", stall_mul, 1'b0);
    step();
    chk("div_nobusy", busy, 1'b0);
    funct3E = 3'b000; flushE = 1'b1; #1;
    chk("flush_idle_nostall", stall_mul, 1'b0);
    step();
    chk("flush_idle_nobusy", busy, 1'b0);
    mul_validE = 1'b0; flushE = 1'b0;

    // flush 10 cycles into WAIT; the late ready must be ignored
    s_start = n_start; s_wb = n_wb;
    m_lat = 34;
    mul_validE = 1'b1; rs1E = 32'd3; rs2E = 32'd4; rdE = 5'd10;
    step(); mul_validE = 1'b0;
    step();
    repeat (10) step();
    chk("flush_wait_busy", busy, 1'b1);
    flushE = 1'b1;
    step();
    flushE = 1'b0; #1;
    chk("flush_abort", {busy, stall_mul}, 2'b00);
    repeat (40) step();
    chk("flush_no_wb", n_wb - s_wb, 0);
    chk("flush_no_restart", n_start - s_start, 1);

    m_dead = 1'b1;
    run_op("timeout", 3'b000, 32'd5, 32'd5, 5'd11, 1, 32'h0, 1'b1, TO + 2);
    m_dead = 1'b0;

    run_op("b2b_a", 3'b000, 32'd9, 32'd9, 5'd12, 3, 32'd81, 1'b0, 5);
    run_op("b2b_b", 3'b000, 32'd100, 32'd3, 5'd13, 3, 32'd300, 1'b0, 5);

    // reset during WAIT
    s_start = n_start; s_wb = n_wb;
    m_lat = 34;
    mul_validE = 1'b1; rs1E = 32'd2; rs2E = 32'd2; rdE = 5'd14;
    step(); mul_validE = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("rst_wait_outs", {stall_mul, mul_start, wb_valid, mul_err, busy, wb_rd, wb_data}, '0);
    rst = 1'b0;
    repeat (40) step();
    chk("rst_wait_nowb", n_wb - s_wb, 0);
    chk("rst_wait_nstart", n_start - s_start, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
